alu_op_sequencer: RTL and testbench

//  Multi-cycle control sequencer that drives the ALU/datapath control side: fetches, decodes IR[31:27],

---
 rtl/alu_op_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Multi-cycle control sequencer for the bus datapath. It fetches an
//   instruction (T0..T2), latches opcode IR[31:27] at the T2->T3 edge, then
//   drives register-select, bus, ALU and memory strobes for each T-state.
//   Every output is registered: the state register and the output register
//   both load from the next-state decode, so outputs change on the same edge
//   as the state and never glitch.
//
// Parameters
//   MEM_TO    cycles a memory state may wait for mem_ack before FAULT (0 = forever)
//   HALT_OPC  opcode that parks the machine in HALT
//
// Configuration macro
//   MULDIV_EN  defined: opcodes 01110/01111 run the mul/div sequence (LO then HI)
//              undefined: those opcodes behave as nop; Zhighout/HIin/LOin stay 0
//
// Ports
//   clock                       in   system clock, rising edge
//   clear                       in   asynchronous active-low reset
//   IR[31:0]                    in   instruction register, opcode = IR[31:27]
//   mem_ack                     in   pending Read/Write completes this cycle
//   ALU_ctl[4:0]                out  ALU operation code
//   IncPC                       out  ALU computes PC+1
//   PCout,PCin,MARin,MDRin,MDRout,IRin   out  datapath strobes
//   Gra,Grb,Grc,Rin,Rout,BAout,Cout      out  register-select / bus strobes
//   Yin,Zin,Zlowout,Zhighout,HIin,LOin   out  ALU operand / result strobes
//   Read,Write                  out  memory requests
//   run                         out  high while sequencing T0..T7
//   fault                       out  high in FAULT (memory timeout) until clear
module alu_op_sequencer #(
  parameter int          MEM_TO   = 16,
  parameter logic [4:0]  HALT_OPC = 5'b11011
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        mem_ack,
  output logic [4:0]  ALU_ctl,
  output logic        IncPC,
  output logic        PCout, PCin, MARin, MDRin, MDRout, IRin,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout,
  output logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin,
  output logic        Read, Write,
  output logic        run,
  output logic        fault
);

`ifdef MULDIV_EN
  localparam bit MD_ON = 1'b1;
`else
  localparam bit MD_ON = 1'b0;
`endif

  localparam int         CW       = $clog2(MEM_TO + 2);
  localparam logic [4:0] ALU_PASS = 5'b00011;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT, S_FAULT
  } state_t;

  typedef struct packed {
    logic       IncPC, PCout, PCin, MARin, MDRin, MDRout, IRin;
    logic       Gra, Grb, Grc, Rin, Rout, BAout, Cout;
    logic       Yin, Zin, Zlowout, Zhighout, HIin, LOin;
    logic       Read, Write;
    logic [4:0] alu;
    logic       run, fault;
  } ctl_t;

  state_t          r_state;
  logic [4:0]      r_opc;
  logic [CW-1:0]   r_wait;
  ctl_t            r_out;

  state_t          w_nxt;
  state_t          w_adv;
  logic [4:0]      w_opc;
  logic            w_tmo;
  logic            w_unused_ir;

  // Only the opcode field is decoded here; the operand fields go to the datapath.
  assign w_unused_ir = ^IR[26:0];

  function automatic logic is_ld(input logic [4:0] o);  return o == 5'b00000; endfunction
  function automatic logic is_ldi(input logic [4:0] o); return o == 5'b00001; endfunction
  function automatic logic is_st(input logic [4:0] o);  return o == 5'b00010; endfunction
  function automatic logic is_rr(input logic [4:0] o);
    return (o >= 5'b00011) && (o <= 5'b01010);
  endfunction
  function automatic logic is_imm(input logic [4:0] o);
    return (o >= 5'b01011) && (o <= 5'b01101);
  endfunction
  function automatic logic is_md(input logic [4:0] o);
    return MD_ON && ((o == 5'b01110) || (o == 5'b01111));
  endfunction
  function automatic logic is_nn(input logic [4:0] o);
    return (o == 5'b10000) || (o == 5'b10001);
  endfunction
  function automatic logic is_valid(input logic [4:0] o);
    return is_ld(o) || is_ldi(o) || is_st(o) || is_rr(o) || is_imm(o) || is_md(o) || is_nn(o);
  endfunction

  // States that issue Read or Write and therefore wait on mem_ack.
  function automatic logic is_mem(input state_t st, input logic [4:0] o);
    return (st == S_T1) || (st == S_T6 && is_ld(o)) || (st == S_T7 && is_st(o));
  endfunction

  function automatic ctl_t decode(input state_t st, input logic [4:0] o);
    ctl_t c;
    c       = '0;
    c.alu   = ALU_PASS;
    c.run   = (st >= S_T0) && (st <= S_T7);
    c.fault = (st == S_FAULT);
    case (st)
      S_RST: c.alu = '0;
      S_T0: begin c.PCout = 1'b1; c.MARin = 1'b1; c.IncPC = 1'b1; c.Zin = 1'b1; end
      S_T1: begin c.Zlowout = 1'b1; c.PCin = 1'b1; c.Read = 1'b1; c.MDRin = 1'b1; end
      S_T2: begin c.MDRout = 1'b1; c.IRin = 1'b1; end
      S_T3: begin
        c.Yin = 1'b1;
        if (is_md(o)) begin c.Gra = 1'b1; c.Rout = 1'b1; end
        else if (is_ld(o) || is_ldi(o) || is_st(o)) begin c.Grb = 1'b1; c.BAout = 1'b1; end
        else begin c.Grb = 1'b1; c.Rout = 1'b1; end
      end
      S_T4: begin
        c.Zin = 1'b1;
        if (is_ld(o) || is_ldi(o) || is_st(o)) begin
          c.Cout = 1'b1;
        end else begin
          c.alu = o;
          if (is_rr(o))       begin c.Grc = 1'b1; c.Rout = 1'b1; end
          else if (is_imm(o)) c.Cout = 1'b1;
          else if (is_md(o))  begin c.Grb = 1'b1; c.Rout = 1'b1; end
        end
      end
      S_T5: begin
        c.Zlowout = 1'b1;
        if (is_md(o))                   c.LOin = 1'b1;
        else if (is_ld(o) || is_st(o))  c.MARin = 1'b1;
        else begin c.Gra = 1'b1; c.Rin = 1'b1; end
      end
      S_T6: begin
        if (is_md(o))      begin c.Zhighout = 1'b1; c.HIin = 1'b1; end
        else if (is_ld(o)) begin c.Read = 1'b1; c.MDRin = 1'b1; end
        else if (is_st(o)) begin c.Gra = 1'b1; c.Rout = 1'b1; c.MDRin = 1'b1; end
      end
      S_T7: begin
        if (is_ld(o))      begin c.MDRout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
        else if (is_st(o)) c.Write = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  assign w_tmo = (MEM_TO != 0) && (int'(r_wait) == MEM_TO - 1);

  always_comb begin
    w_opc = r_opc;
    w_adv = r_state;
    case (r_state)
      S_RST: w_adv = S_T0;
      S_T0:  w_adv = S_T1;
      S_T1:  w_adv = S_T2;
      S_T2: begin
        w_opc = IR[31:27];
        if (IR[31:27] == HALT_OPC)   w_adv = S_HALT;
        else if (is_valid(IR[31:27])) w_adv = S_T3;
        else                          w_adv = S_T0;
      end
      S_T3:  w_adv = S_T4;
      S_T4:  w_adv = S_T5;
      S_T5:  w_adv = (is_ld(r_opc) || is_st(r_opc) || is_md(r_opc)) ? S_T6 : S_T0;
      S_T6:  w_adv = is_md(r_opc) ? S_T0 : S_T7;
      S_T7:  w_adv = S_T0;
      default: w_adv = r_state;
    endcase
    // Memory states hold their strobes until acknowledged; ack wins over timeout.
    w_nxt = w_adv;
    if (is_mem(r_state, r_opc) && !mem_ack)
      w_nxt = w_tmo ? S_FAULT : r_state;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= S_RST;
      r_opc   <= '0;
      r_wait  <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_nxt;
      r_opc   <= w_opc;
      // Restarts on every state change, so each memory state gets a fresh budget.
      r_wait  <= (w_nxt == r_state) ? r_wait + 1'b1 : '0;
      r_out   <= decode(w_nxt, w_opc);
    end
  end

  assign ALU_ctl  = r_out.alu;
  assign IncPC    = r_out.IncPC;
  assign PCout    = r_out.PCout;
  assign PCin     = r_out.PCin;
  assign MARin    = r_out.MARin;
  assign MDRin    = r_out.MDRin;
  assign MDRout   = r_out.MDRout;
  assign IRin     = r_out.IRin;
  assign Gra      = r_out.Gra;
  assign Grb      = r_out.Grb;
  assign Grc      = r_out.Grc;
  assign Rin      = r_out.Rin;
  assign Rout     = r_out.Rout;
  assign BAout    = r_out.BAout;
  assign Cout     = r_out.Cout;
  assign Yin      = r_out.Yin;
  assign Zin      = r_out.Zin;
  assign Zlowout  = r_out.Zlowout;
  assign Zhighout = r_out.Zhighout;
  assign HIin     = r_out.HIin;
  assign LOin     = r_out.LOin;
  assign Read     = r_out.Read;
  assign Write    = r_out.Write;
  assign run      = r_out.run;
  assign fault    = r_out.fault;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
//   Directed-vector bench for alu_op_sequencer (MEM_TO = 4). Each cycle's
//   expected strobe set is written out by hand from the instruction tables.
module tb_alu_op_sequencer;

  logic        clock, clear, mem_ack;
  logic [31:0] IR;
  logic [4:0]  ALU_ctl;
  logic        IncPC, PCout, PCin, MARin, MDRin, MDRout, IRin;
  logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout;
  logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin;
  logic        Read, Write, run, fault;

  int n_checks = 0;
  int n_fail   = 0;

  alu_op_sequencer #(.MEM_TO(4), .HALT_OPC(5'b11011)) dut (
    .clock(clock), .clear(clear), .IR(IR), .mem_ack(mem_ack),
    .ALU_ctl(ALU_ctl), .IncPC(IncPC),
    .PCout(PCout), .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
    .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
    .Read(Read), .Write(Write), .run(run), .fault(fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Strobe bit positions in the packed observation vector.
  localparam logic [21:0] INCPC = 22'b1 << 21, PCOUT = 22'b1 << 20, PCIN  = 22'b1 << 19;
  localparam logic [21:0] MARIN = 22'b1 << 18, MDRIN = 22'b1 << 17, MDROUT = 22'b1 << 16;
  localparam logic [21:0] IRIN  = 22'b1 << 15, GRA   = 22'b1 << 14, GRB   = 22'b1 << 13;
  localparam logic [21:0] GRC   = 22'b1 << 12, RIN   = 22'b1 << 11, ROUT  = 22'b1 << 10;
  localparam logic [21:0] BAOUT = 22'b1 << 9,  COUT  = 22'b1 << 8,  YIN   = 22'b1 << 7;
  localparam logic [21:0] ZIN   = 22'b1 << 6,  ZLOW  = 22'b1 << 5,  ZHIGH = 22'b1 << 4;
  localparam logic [21:0] HIIN  = 22'b1 << 3,  LOIN  = 22'b1 << 2,  READ  = 22'b1 << 1;
  localparam logic [21:0] WRITE = 22'b1;

  localparam logic [21:0] F0 = INCPC | PCOUT | MARIN | ZIN;
  localparam logic [21:0] F1 = ZLOW | PCIN | READ | MDRIN;
  localparam logic [21:0] F2 = MDROUT | IRIN;

  logic [21:0] obs_s;
  assign obs_s = {IncPC, PCout, PCin, MARin, MDRin, MDRout, IRin, Gra, Grb, Grc, Rin, Rout,
                  BAout, Cout, Yin, Zin, Zlowout, Zhighout, HIin, LOin, Read, Write};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // rf = {run, fault}
  task automatic expect_cyc(input string tag, input logic [21:0] s, input logic [4:0] alu,
                            input logic [1:0] rf);
    check_eq({tag, ".strobes"}, 32'(obs_s), 32'(s));
    check_eq({tag, ".alu"}, 32'(ALU_ctl), 32'(alu));
    check_eq({tag, ".run_fault"}, 32'({run, fault}), 32'(rf));
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // Entered sampled in T0; leaves having stepped past T2.
  task automatic run_fetch(input string tag);
    expect_cyc({tag, ".T0"}, F0, 5'b00011, 2'b10);
    step();
    expect_cyc({tag, ".T1"}, F1, 5'b00011, 2'b10);
    step();
    expect_cyc({tag, ".T2"}, F2, 5'b00011, 2'b10);
    step();
  endtask

  initial begin
    clear   = 1'b0;
    mem_ack = 1'b1;
    IR      = 32'h0;
    #3;
    expect_cyc("reset", 22'h0, 5'b00000, 2'b00);
    step();
    step();
    expect_cyc("reset_hold", 22'h0, 5'b00000, 2'b00);
    clear = 1'b1;
    step();

    // add: six cycles T0..T5
    IR = {5'b00011, 27'h0};
    run_fetch("add");
    expect_cyc("add.T3", GRB | ROUT | YIN, 5'b00011, 2'b10);
    step();
    expect_cyc("add.T4", GRC | ROUT | ZIN, 5'b00011, 2'b10);
    step();
    expect_cyc("add.T5", ZLOW | GRA | RIN, 5'b00011, 2'b10);
    step();

    // clear mid-T4 of add
    run_fetch("abort");
    step();
    expect_cyc("abort.T4", GRC | ROUT | ZIN, 5'b00011, 2'b10);
    #3;
    clear = 1'b0;
    #1;
    expect_cyc("abort.async", 22'h0, 5'b00000, 2'b00);
    step();
    expect_cyc("abort.held", 22'h0, 5'b00000, 2'b00);
    clear = 1'b1;
    step();

    // imm with IR changed after latch
    IR = {5'b01011, 27'h0};
    run_fetch("imm");
    expect_cyc("imm.T3", GRB | ROUT | YIN, 5'b00011, 2'b10);
    IR = {5'b10000, 27'h0};
    step();
    expect_cyc("imm.T4", COUT | ZIN, 5'b01011, 2'b10);
    step();
    expect_cyc("imm.T5", ZLOW | GRA | RIN, 5'b00011, 2'b10);
    step();

    // neg
    run_fetch("neg");
    expect_cyc("neg.T3", GRB | ROUT | YIN, 5'b00011, 2'b10);
    step();
    expect_cyc("neg.T4", ZIN, 5'b10000, 2'b10);
    step();
    expect_cyc("neg.T5", ZLOW | GRA | RIN, 5'b00011, 2'b10);
    step();

    // ld with mem_ack withheld for three T6 cycles
    IR = {5'b00000, 27'h0};
    run_fetch("ld");
    expect_cyc("ld.T3", GRB | BAOUT | YIN, 5'b00011, 2'b10);
    step();
    expect_cyc("ld.T4", COUT | ZIN, 5'b00011, 2'b10);
    step();
    expect_cyc("ld.T5", ZLOW | MARIN, 5'b00011, 2'b10);
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_cyc($sformatf("ld.T6w%0d", i), READ | MDRIN, 5'b00011, 2'b10);
    end
    mem_ack = 1'b1;
    step();
    expect_cyc("ld.T7", MDROUT | GRA | RIN, 5'b00011, 2'b10);
    step();

    // ldi
    IR = {5'b00001, 27'h0};
    run_fetch("ldi");
    expect_cyc("ldi.T3", GRB | BAOUT | YIN, 5'b00011, 2'b10);
    step();
    expect_cyc("ldi.T4", COUT | ZIN, 5'b00011, 2'b10);
    step();
    expect_cyc("ldi.T5", ZLOW | GRA | RIN, 5'b00011, 2'b10);
    step();

    // st
    IR = {5'b00010, 27'h0};
    run_fetch("st");
    expect_cyc("st.T3", GRB | BAOUT | YIN, 5'b00011, 2'b10);
    step();
    expect_cyc("st.T4", COUT | ZIN, 5'b00011, 2'b10);
    step();
    expect_cyc("st.T5", ZLOW | MARIN, 5'b00011, 2'b10);
    step();
    expect_cyc("st.T6", GRA | ROUT | MDRIN, 5'b00011, 2'b10);
    step();
    expect_cyc("st.T7", WRITE, 5'b00011, 2'b10);
    step();

    // mul
    IR = {5'b01110, 27'h0};
    run_fetch("mul");
`ifdef MULDIV_EN
    expect_cyc("mul.T3", GRA | ROUT | YIN, 5'b00011, 2'b10);
    step();
    expect_cyc("mul.T4", GRB | ROUT | ZIN, 5'b01110, 2'b10);
    step();
    expect_cyc("mul.T5", ZLOW | LOIN, 5'b00011, 2'b10);
    step();
    expect_cyc("mul.T6", ZHIGH | HIIN, 5'b00011, 2'b10);
    step();
`endif

    // undefined opcode: nop back to T0
    IR = {5'b10010, 27'h0};
    run_fetch("undef");

    // memory timeout in T1
    expect_cyc("tmo.T0", F0, 5'b00011, 2'b10);
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_cyc($sformatf("tmo.T1w%0d", i), F1, 5'b00011, 2'b10);
    end
    step();
    check_eq("tmo.fault.strobes", 32'(obs_s), 32'h0);
    check_eq("tmo.fault.run_fault", 32'({run, fault}), 32'(2'b01));
    for (int i = 0; i < 3; i++) begin
      mem_ack = ~mem_ack;
      step();
      check_eq($sformatf("tmo.sticky%0d.strobes", i), 32'(obs_s), 32'h0);
      check_eq($sformatf("tmo.sticky%0d.run_fault", i), 32'({run, fault}), 32'(2'b01));
    end
    clear = 1'b0;
    #1;
    check_eq("tmo.clear.run_fault", 32'({run, fault}), 32'(2'b00));
    mem_ack = 1'b1;
    #2;
    clear = 1'b1;
    step();

    // halt
    IR = {5'b11011, 27'h0};
    run_fetch("halt");
    check_eq("halt.strobes", 32'(obs_s), 32'h0);
    check_eq("halt.run_fault", 32'({run, fault}), 32'(2'b00));
    for (int i = 0; i < 3; i++) begin
      IR      = {5'b00011, 27'h0} ^ 32'(i);
      mem_ack = ~mem_ack;
      step();
      check_eq($sformatf("halt.stay%0d.strobes", i), 32'(obs_s), 32'h0);
      check_eq($sformatf("halt.stay%0d.run_fault", i), 32'({run, fault}), 32'(2'b00));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
